// File: rtl/iic_reg_bank_ctrl.sv
// IIC slave register bank: pointer decode, auto-increment, local port; all outputs 1-cycle latency.
// No backpressure: every slave or local strobe is consumed in the cycle it arrives.
module iic_reg_bank_ctrl #(
    parameter int                    NUM_REGS  = 16,
    parameter int                    ADDR_W    = 4,
    parameter logic [7:0]            RESET_VAL = 8'h00,
    parameter logic [NUM_REGS-1:0]   RO_MASK   = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        Slv_Data_Out,
    input  logic              Slv_Byte_TC,
    input  logic              Slv_Read_Req,
    input  logic              Slv_P,
    output logic [7:0]        Slv_Data_In,
    input  logic [ADDR_W-1:0] Usr_Addr,
    input  logic              Usr_Wr,
    input  logic [7:0]        Usr_Wdata,
    output logic [7:0]        Usr_Rdata,
    output logic              Usr_Collision,
    output logic              Reg_Wr_Strobe,
    output logic [ADDR_W-1:0] Reg_Wr_Addr,
    output logic [ADDR_W-1:0] Ptr
);

    typedef enum logic {S_PTR, S_DATA} state_t;

    localparam int FULL = 2 ** ADDR_W;
    localparam logic [FULL-1:0] RO_FULL = FULL'(RO_MASK);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic [7:0]         r_bank [NUM_REGS];

    logic               w_ptr_ok;
    logic               w_usr_ok;
    logic [ADDR_W-1:0]  w_ptr_inc;
    logic               w_iic_commit;
    logic               w_usr_commit;
    logic               w_collision;

    assign w_ptr_ok  = (32'(r_ptr) < NUM_REGS);
    assign w_usr_ok  = (32'(Usr_Addr) < NUM_REGS);
    // Out-of-range pointers and the last register both wrap to zero.
    assign w_ptr_inc = (!w_ptr_ok || (32'(r_ptr) == NUM_REGS - 1)) ? '0 : r_ptr + ADDR_W'(1);

    assign w_iic_commit = Slv_Byte_TC && (r_state == S_DATA) && w_ptr_ok && !RO_FULL[r_ptr];
    assign w_usr_commit = Usr_Wr && w_usr_ok;
    assign w_collision  = w_usr_commit && w_iic_commit && (Usr_Addr == r_ptr);

    assign Ptr = r_ptr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) r_bank[i] <= RESET_VAL;
            r_state       <= S_PTR;
            r_ptr         <= '0;
            Slv_Data_In   <= 8'h00;
            Usr_Rdata     <= 8'h00;
            Usr_Collision <= 1'b0;
            Reg_Wr_Strobe <= 1'b0;
            Reg_Wr_Addr   <= '0;
        end else begin
            // IIC data takes priority over a local write to the same register.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_iic_commit && (32'(r_ptr) == i))
                    r_bank[i] <= Slv_Data_Out;
                else if (w_usr_commit && (32'(Usr_Addr) == i))
                    r_bank[i] <= Usr_Wdata;
            end

            Usr_Rdata     <= w_usr_ok ? r_bank[Usr_Addr] : 8'hFF;
            Usr_Collision <= w_collision;
            Reg_Wr_Strobe <= w_iic_commit;
            if (w_iic_commit)
                Reg_Wr_Addr <= r_ptr;

            if (Slv_Byte_TC) begin
                if (r_state == S_PTR) begin
                    r_ptr   <= Slv_Data_Out[ADDR_W-1:0];
                    r_state <= S_DATA;
                end else begin
                    r_ptr <= w_ptr_inc;
                end
            end else if (Slv_Read_Req) begin
                Slv_Data_In <= w_ptr_ok ? r_bank[r_ptr] : 8'hFF;
                r_ptr       <= w_ptr_inc;
            end

            if (Slv_P)
                r_state <= S_PTR;
        end
    end

endmodule

// File: tb/tb_iic_reg_bank_ctrl.sv
// Directed bench for iic_reg_bank_ctrl with register 2 read-only from the IIC side.
module tb_iic_reg_bank_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] Slv_Data_Out;
    logic       Slv_Byte_TC;
    logic       Slv_Read_Req;
    logic       Slv_P;
    logic [7:0] Slv_Data_In;
    logic [3:0] Usr_Addr;
    logic       Usr_Wr;
    logic [7:0] Usr_Wdata;
    logic [7:0] Usr_Rdata;
    logic       Usr_Collision;
    logic       Reg_Wr_Strobe;
    logic [3:0] Reg_Wr_Addr;
    logic [3:0] Ptr;

    int checks = 0;
    int errors = 0;

    iic_reg_bank_ctrl #(
        .NUM_REGS (16),
        .ADDR_W   (4),
        .RESET_VAL(8'h00),
        .RO_MASK  (16'h0004)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Slv_Data_Out (Slv_Data_Out),
        .Slv_Byte_TC  (Slv_Byte_TC),
        .Slv_Read_Req (Slv_Read_Req),
        .Slv_P        (Slv_P),
        .Slv_Data_In  (Slv_Data_In),
        .Usr_Addr     (Usr_Addr),
        .Usr_Wr       (Usr_Wr),
        .Usr_Wdata    (Usr_Wdata),
        .Usr_Rdata    (Usr_Rdata),
        .Usr_Collision(Usr_Collision),
        .Reg_Wr_Strobe(Reg_Wr_Strobe),
        .Reg_Wr_Addr  (Reg_Wr_Addr),
        .Ptr          (Ptr)
    );

    always #5 CLK = ~CLK;

    // Stimulus helpers: inputs change on the falling edge, outputs are sampled on the next one.
    task automatic wr_byte(input logic [7:0] b);
        Slv_Data_Out = b;
        Slv_Byte_TC  = 1'b1;
        @(negedge CLK);
        Slv_Byte_TC  = 1'b0;
    endtask

    task automatic stop_cond();
        Slv_P = 1'b1;
        @(negedge CLK);
        Slv_P = 1'b0;
    endtask

    task automatic rd_req();
        Slv_Read_Req = 1'b1;
        @(negedge CLK);
        Slv_Read_Req = 1'b0;
    endtask

    task automatic usr_write(input logic [3:0] a, input logic [7:0] d);
        Usr_Addr  = a;
        Usr_Wdata = d;
        Usr_Wr    = 1'b1;
        @(negedge CLK);
        Usr_Wr    = 1'b0;
    endtask

    task automatic usr_read(input logic [3:0] a, output logic [7:0] d);
        Usr_Addr = a;
        @(negedge CLK);
        d = Usr_Rdata;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (Ptr !== 4'd0) begin errors++; $display("FAIL reset_ptr: got %0h want 0", Ptr); end
        checks++; if (Slv_Data_In !== 8'h00) begin errors++; $display("FAIL reset_sdi: got %0h want 00", Slv_Data_In); end
        checks++; if (Usr_Rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %0h want 00", Usr_Rdata); end
        checks++; if ({Usr_Collision, Reg_Wr_Strobe, Reg_Wr_Addr} !== 6'd0) begin
            errors++; $display("FAIL reset_flags: got %b/%b/%0h want 0/0/0", Usr_Collision, Reg_Wr_Strobe, Reg_Wr_Addr);
        end
    endtask

    task automatic test_write_burst();
        logic [7:0] d;
        wr_byte(8'h03);
        checks++; if (Reg_Wr_Strobe !== 1'b0) begin errors++; $display("FAIL wb_ptr_nostrobe: got %b want 0", Reg_Wr_Strobe); end
        wr_byte(8'hA5);
        checks++; if (Reg_Wr_Strobe !== 1'b1 || Reg_Wr_Addr !== 4'd3) begin
            errors++; $display("FAIL wb_strobe3: got %b/%0h want 1/3", Reg_Wr_Strobe, Reg_Wr_Addr);
        end
        wr_byte(8'h5A);
        checks++; if (Reg_Wr_Strobe !== 1'b1 || Reg_Wr_Addr !== 4'd4) begin
            errors++; $display("FAIL wb_strobe4: got %b/%0h want 1/4", Reg_Wr_Strobe, Reg_Wr_Addr);
        end
        stop_cond();
        checks++; if (Reg_Wr_Strobe !== 1'b0) begin errors++; $display("FAIL wb_strobe_clear: got %b want 0", Reg_Wr_Strobe); end
        checks++; if (Ptr !== 4'd5) begin errors++; $display("FAIL wb_ptr: got %0h want 5", Ptr); end
        usr_read(4'd3, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL wb_reg3: got %0h want a5", d); end
        usr_read(4'd4, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL wb_reg4: got %0h want 5a", d); end
        // After STOP the next byte must be a pointer.
        wr_byte(8'hF7);
        checks++; if (Ptr !== 4'd7 || Reg_Wr_Strobe !== 1'b0) begin
            errors++; $display("FAIL wb_after_stop: got ptr %0h strobe %b want 7/0", Ptr, Reg_Wr_Strobe);
        end
        stop_cond();
    endtask

    task automatic test_read_wrap();
        usr_write(4'd15, 8'hC3);
        usr_write(4'd0, 8'h3C);
        wr_byte(8'h0F);
        stop_cond();
        rd_req();
        checks++; if (Slv_Data_In !== 8'hC3 || Ptr !== 4'd0) begin
            errors++; $display("FAIL rd_reg15: got %0h ptr %0h want c3/0", Slv_Data_In, Ptr);
        end
        rd_req();
        checks++; if (Slv_Data_In !== 8'h3C || Ptr !== 4'd1) begin
            errors++; $display("FAIL rd_reg0: got %0h ptr %0h want 3c/1", Slv_Data_In, Ptr);
        end
        rd_req();
        checks++; if (Slv_Data_In !== 8'h00 || Ptr !== 4'd2) begin
            errors++; $display("FAIL rd_cur_addr: got %0h ptr %0h want 00/2", Slv_Data_In, Ptr);
        end
    endtask

    task automatic test_read_only();
        logic [7:0] d;
        wr_byte(8'h02);
        wr_byte(8'h77);
        checks++; if (Reg_Wr_Strobe !== 1'b0 || Ptr !== 4'd3) begin
            errors++; $display("FAIL ro_nostrobe: got strobe %b ptr %0h want 0/3", Reg_Wr_Strobe, Ptr);
        end
        stop_cond();
        usr_read(4'd2, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ro_reg2: got %0h want 00", d); end
    endtask

    task automatic test_collision();
        logic [7:0] d;
        wr_byte(8'h01);
        Usr_Addr = 4'd1; Usr_Wdata = 8'h22; Usr_Wr = 1'b1;
        wr_byte(8'h11);
        Usr_Wr = 1'b0;
        checks++; if (Usr_Collision !== 1'b1 || Reg_Wr_Strobe !== 1'b1 || Reg_Wr_Addr !== 4'd1) begin
            errors++; $display("FAIL col_pulse: got col %b strobe %b addr %0h want 1/1/1", Usr_Collision, Reg_Wr_Strobe, Reg_Wr_Addr);
        end
        stop_cond();
        checks++; if (Usr_Collision !== 1'b0) begin errors++; $display("FAIL col_clear: got %b want 0", Usr_Collision); end
        usr_read(4'd1, d);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL col_reg1: got %0h want 11", d); end

        wr_byte(8'h01);
        Usr_Addr = 4'd2; Usr_Wdata = 8'h22; Usr_Wr = 1'b1;
        wr_byte(8'h33);
        Usr_Wr = 1'b0;
        checks++; if (Usr_Collision !== 1'b0 || Reg_Wr_Strobe !== 1'b1) begin
            errors++; $display("FAIL nocol_flags: got col %b strobe %b want 0/1", Usr_Collision, Reg_Wr_Strobe);
        end
        checks++; if (Usr_Rdata !== 8'h00) begin errors++; $display("FAIL rdata_old: got %0h want 00", Usr_Rdata); end
        stop_cond();
        usr_read(4'd2, d);
        checks++; if (d !== 8'h22) begin errors++; $display("FAIL nocol_reg2: got %0h want 22", d); end
        usr_read(4'd1, d);
        checks++; if (d !== 8'h33) begin errors++; $display("FAIL nocol_reg1: got %0h want 33", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        wr_byte(8'h0A);
        Slv_P = 1'b1;
        wr_byte(8'h05);
        Slv_P = 1'b0;
        checks++; if (Reg_Wr_Strobe !== 1'b1 || Reg_Wr_Addr !== 4'd10 || Ptr !== 4'd11) begin
            errors++; $display("FAIL p_tc_commit: got strobe %b addr %0h ptr %0h want 1/a/b", Reg_Wr_Strobe, Reg_Wr_Addr, Ptr);
        end
        wr_byte(8'h0C);
        checks++; if (Ptr !== 4'd12 || Reg_Wr_Strobe !== 1'b0) begin
            errors++; $display("FAIL p_tc_ptr_next: got ptr %0h strobe %b want c/0", Ptr, Reg_Wr_Strobe);
        end
        stop_cond();
        usr_read(4'd10, d);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL p_tc_reg10: got %0h want 05", d); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        wr_byte(8'h06);
        checks++; if (Ptr !== 4'd6) begin errors++; $display("FAIL mr_ptr6: got %0h want 6", Ptr); end
        Usr_Addr = 4'd3;
        do_reset();
        checks++; if (Ptr !== 4'd0 || Usr_Rdata !== 8'h00) begin
            errors++; $display("FAIL mr_state: got ptr %0h rdata %0h want 0/00", Ptr, Usr_Rdata);
        end
        usr_read(4'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mr_reg1: got %0h want 00", d); end
        usr_read(4'd15, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mr_reg15: got %0h want 00", d); end
        wr_byte(8'h09);
        checks++; if (Ptr !== 4'd9 || Reg_Wr_Strobe !== 1'b0) begin
            errors++; $display("FAIL mr_ptr_byte: got ptr %0h strobe %b want 9/0", Ptr, Reg_Wr_Strobe);
        end
        wr_byte(8'hAB);
        checks++; if (Reg_Wr_Strobe !== 1'b1 || Reg_Wr_Addr !== 4'd9) begin
            errors++; $display("FAIL mr_commit: got strobe %b addr %0h want 1/9", Reg_Wr_Strobe, Reg_Wr_Addr);
        end
        stop_cond();
    endtask

    initial begin
        RST = 1'b1; Slv_Data_Out = 8'h00; Slv_Byte_TC = 1'b0; Slv_Read_Req = 1'b0; Slv_P = 1'b0;
        Usr_Addr = 4'd0; Usr_Wr = 1'b0; Usr_Wdata = 8'h00;
        @(negedge CLK);
        test_reset();
        test_write_burst();
        test_read_wrap();
        test_read_only();
        test_collision();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
